// File: rtl/fpu_pkg.sv
// ---------------------------------------------------------------------------
// fpu_pkg
//   Shared constants and types for the FP adder front end.
//   - FP_E_SIZE / FP_M_SIZE : default exponent / mantissa field widths
//   - FP_GRS_W              : guard/round/sticky extension below the LSB
//   - FP_EXP_ONES           : all-ones exponent (Inf/NaN marker)
//   - align_state_t         : alignment stage FSM states
// ---------------------------------------------------------------------------
package fpu_pkg;

  localparam int FP_E_SIZE     = 8;
  localparam int FP_M_SIZE     = 23;
  localparam int FP_TOTAL_SIZE = 1 + FP_E_SIZE + FP_M_SIZE;
  localparam int FP_GRS_W      = 3;
  localparam int FP_SHIFT_STEP = 4;

  localparam logic [FP_E_SIZE-1:0] FP_EXP_ONES = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } align_state_t;

endpackage

// File: rtl/fpu_unpack.sv
// ---------------------------------------------------------------------------
// fpu_unpack (combinational)
//   Splits an operand pair into fields, restores the hidden bit, flags
//   Inf/NaN and orders the pair by exponent.
//   Ports:
//     a, b        in   operands
//     exp_big     out  larger effective exponent (exp==0 counts as 1)
//     diff        out  exponent difference, big minus small
//     sign_big    out  sign of larger-exponent operand
//     sign_small  out  sign of the other operand
//     mant_big    out  {hidden, mant, GRS=0} of larger operand
//     mant_small  out  {hidden, mant, GRS=0} of other operand (unshifted)
//     swap        out  1 when B has the strictly larger exponent
//     special     out  either raw exponent all-ones
// ---------------------------------------------------------------------------
module fpu_unpack
  import fpu_pkg::*;
#(
  parameter int M_SIZE     = FP_M_SIZE,
  parameter int E_SIZE     = FP_E_SIZE,
  parameter int TOTAL_SIZE = 1 + E_SIZE + M_SIZE
) (
  input  logic [TOTAL_SIZE-1:0] a,
  input  logic [TOTAL_SIZE-1:0] b,
  output logic [E_SIZE-1:0]     exp_big,
  output logic [E_SIZE-1:0]     diff,
  output logic                  sign_big,
  output logic                  sign_small,
  output logic [M_SIZE+3:0]     mant_big,
  output logic [M_SIZE+3:0]     mant_small,
  output logic                  swap,
  output logic                  special
);

  logic [E_SIZE-1:0] exp_a_raw, exp_b_raw;
  logic [E_SIZE-1:0] exp_a, exp_b;
  logic [M_SIZE:0]   sig_a, sig_b;

  assign exp_a_raw = a[TOTAL_SIZE-2 -: E_SIZE];
  assign exp_b_raw = b[TOTAL_SIZE-2 -: E_SIZE];

  // Denormals share the scale of exponent 1; only the hidden bit differs.
  assign exp_a = (exp_a_raw == '0) ? E_SIZE'(1) : exp_a_raw;
  assign exp_b = (exp_b_raw == '0) ? E_SIZE'(1) : exp_b_raw;

  assign sig_a = {|exp_a_raw, a[M_SIZE-1:0]};
  assign sig_b = {|exp_b_raw, b[M_SIZE-1:0]};

  // Ties keep A as the big operand.
  assign swap    = (exp_b > exp_a);
  assign special = (&exp_a_raw) | (&exp_b_raw);

  assign exp_big    = swap ? exp_b : exp_a;
  assign diff       = swap ? (exp_b - exp_a) : (exp_a - exp_b);
  assign sign_big   = swap ? b[TOTAL_SIZE-1] : a[TOTAL_SIZE-1];
  assign sign_small = swap ? a[TOTAL_SIZE-1] : b[TOTAL_SIZE-1];
  assign mant_big   = {(swap ? sig_b : sig_a), {FP_GRS_W{1'b0}}};
  assign mant_small = {(swap ? sig_a : sig_b), {FP_GRS_W{1'b0}}};

endmodule

// File: rtl/fpu_align_stage.sv
// ---------------------------------------------------------------------------
// fpu_align_stage
//   Operand alignment ahead of the FP adder. Accepts an operand pair over
//   valid/ready, orders it by exponent and right-shifts the smaller mantissa
//   by the exponent difference, keeping guard/round/sticky bits.
//
//   Build option: define FPU_ALIGN_BARREL_EN to align in the accept cycle
//   with a full barrel shift (latency always 1, SHIFT state never entered,
//   SHIFT_STEP has no effect). Without it the shift runs iteratively,
//   SHIFT_STEP bits per cycle.
//
//   Ports:
//     clk, rst_n        clock, asynchronous active-low reset
//     flush             synchronous abort of the in-flight operation
//     in_valid/in_ready operand pair handshake (in_a, in_b)
//     out_valid/out_ready result handshake
//     out_exp           common (larger) exponent
//     out_sign_big/small signs of big / other operand
//     out_mant_big      {hidden, mant, 000}
//     out_mant_small    aligned {hidden, mant, G, R, S}
//     out_swap          B is the big operand
//     out_special       Inf/NaN present, mantissas left unshifted
//     busy              not idle
// ---------------------------------------------------------------------------
module fpu_align_stage
  import fpu_pkg::*;
#(
  parameter int M_SIZE     = FP_M_SIZE,
  parameter int E_SIZE     = FP_E_SIZE,
  parameter int TOTAL_SIZE = 1 + E_SIZE + M_SIZE,
  parameter int SHIFT_STEP = FP_SHIFT_STEP
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [TOTAL_SIZE-1:0] in_a,
  input  logic [TOTAL_SIZE-1:0] in_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [E_SIZE-1:0]     out_exp,
  output logic                  out_sign_big,
  output logic                  out_sign_small,
  output logic [M_SIZE+3:0]     out_mant_big,
  output logic [M_SIZE+3:0]     out_mant_small,
  output logic                  out_swap,
  output logic                  out_special,
  output logic                  busy
);

  localparam int MW = M_SIZE + 4;
  localparam logic [E_SIZE-1:0] STEP  = E_SIZE'(SHIFT_STEP);
  localparam logic [E_SIZE-1:0] MAX_D = E_SIZE'(M_SIZE + 3);

  // Right shift where every bit pushed past the LSB is ORed into bit 0.
  function automatic logic [MW-1:0] sticky_shr(input logic [MW-1:0] m,
                                               input logic [E_SIZE-1:0] amt);
    logic [MW-1:0] r;
    logic          lost;
    r    = m >> amt;
    lost = 1'b0;
    for (int i = 0; i < MW; i++) begin
      if (i < int'(amt)) lost = lost | m[i];
    end
    return {r[MW-1:1], r[0] | lost};
  endfunction

  // Unpacked view of the incoming pair
  logic [E_SIZE-1:0] u_exp_big, u_diff;
  logic              u_sign_big, u_sign_small, u_swap, u_special;
  logic [MW-1:0]     u_mant_big, u_mant_small;

  fpu_unpack #(
    .M_SIZE     (M_SIZE),
    .E_SIZE     (E_SIZE),
    .TOTAL_SIZE (TOTAL_SIZE)
  ) u_unpack (
    .a          (in_a),
    .b          (in_b),
    .exp_big    (u_exp_big),
    .diff       (u_diff),
    .sign_big   (u_sign_big),
    .sign_small (u_sign_small),
    .mant_big   (u_mant_big),
    .mant_small (u_mant_small),
    .swap       (u_swap),
    .special    (u_special)
  );

  align_state_t      state_reg, state_next;
  logic [E_SIZE-1:0] exp_reg, exp_next;
  logic [E_SIZE-1:0] rem_reg, rem_next;
  logic              sign_big_reg, sign_big_next;
  logic              sign_small_reg, sign_small_next;
  logic [MW-1:0]     mant_big_reg, mant_big_next;
  logic [MW-1:0]     mant_small_reg, mant_small_next;
  logic              swap_reg, swap_next;
  logic              special_reg, special_next;

  logic              accept;
  logic              collapse;
  logic [E_SIZE-1:0] amt;

  assign in_ready = (state_reg == IDLE) | ((state_reg == HOLD) & out_ready);
  assign accept   = in_valid & in_ready;
  // Everything would fall below the sticky position: only the OR survives.
  assign collapse = (u_diff > MAX_D);

  always_comb begin
    state_next      = state_reg;
    exp_next        = exp_reg;
    rem_next        = rem_reg;
    sign_big_next   = sign_big_reg;
    sign_small_next = sign_small_reg;
    mant_big_next   = mant_big_reg;
    mant_small_next = mant_small_reg;
    swap_next       = swap_reg;
    special_next    = special_reg;
    amt             = (rem_reg < STEP) ? rem_reg : STEP;

    case (state_reg)
      IDLE: ;
      SHIFT: begin
        mant_small_next = sticky_shr(mant_small_reg, amt);
        rem_next        = rem_reg - amt;
        if (rem_reg == amt) state_next = HOLD;
      end
      HOLD: begin
        if (out_ready && !in_valid) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // Accept is only possible from IDLE or from HOLD during a handshake,
    // so loading here also covers the back-to-back case.
    if (accept) begin
      exp_next        = u_exp_big;
      sign_big_next   = u_sign_big;
      sign_small_next = u_sign_small;
      mant_big_next   = u_mant_big;
      swap_next       = u_swap;
      special_next    = u_special;
      rem_next        = '0;
      if (u_special) begin
        mant_small_next = u_mant_small;
        state_next      = HOLD;
      end else if (collapse) begin
        mant_small_next = {{(MW-1){1'b0}}, |u_mant_small};
        state_next      = HOLD;
      end else begin
`ifdef FPU_ALIGN_BARREL_EN
        mant_small_next = sticky_shr(u_mant_small, u_diff);
        state_next      = HOLD;
`else
        mant_small_next = u_mant_small;
        rem_next        = u_diff;
        state_next      = (u_diff == '0) ? HOLD : SHIFT;
`endif
      end
    end

    if (flush) state_next = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      exp_reg        <= '0;
      rem_reg        <= '0;
      sign_big_reg   <= 1'b0;
      sign_small_reg <= 1'b0;
      mant_big_reg   <= '0;
      mant_small_reg <= '0;
      swap_reg       <= 1'b0;
      special_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      exp_reg        <= exp_next;
      rem_reg        <= rem_next;
      sign_big_reg   <= sign_big_next;
      sign_small_reg <= sign_small_next;
      mant_big_reg   <= mant_big_next;
      mant_small_reg <= mant_small_next;
      swap_reg       <= swap_next;
      special_reg    <= special_next;
    end
  end

  assign out_valid      = (state_reg == HOLD);
  assign busy           = (state_reg != IDLE);
  assign out_exp        = exp_reg;
  assign out_sign_big   = sign_big_reg;
  assign out_sign_small = sign_small_reg;
  assign out_mant_big   = mant_big_reg;
  assign out_mant_small = mant_small_reg;
  assign out_swap       = swap_reg;
  assign out_special    = special_reg;

endmodule

// File: tb/tb_fpu_align_stage.sv
// ---------------------------------------------------------------------------
// tb_fpu_align_stage
//   Directed and randomized checks of the alignment stage against an
//   arithmetic reference model (single precision, SHIFT_STEP = 4).
// ---------------------------------------------------------------------------
module tb_fpu_align_stage;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_a, in_b;
  logic [7:0]  out_exp;
  logic        out_sign_big, out_sign_small, out_swap, out_special, busy;
  logic [26:0] out_mant_big, out_mant_small;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fpu_align_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_a           (in_a),
    .in_b           (in_b),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_exp        (out_exp),
    .out_sign_big   (out_sign_big),
    .out_sign_small (out_sign_small),
    .out_mant_big   (out_mant_big),
    .out_mant_small (out_mant_small),
    .out_swap       (out_swap),
    .out_special    (out_special),
    .busy           (busy)
  );

  typedef struct {
    logic [7:0]  e;
    logic        sb;
    logic        ss;
    logic        sw;
    logic        sp;
    logic [26:0] mb;
    logic [26:0] ms;
    int          lat;
  } exp_t;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Reference: real-number view of alignment (value * 8, shifted right by d,
  // with any nonzero remainder folded into the sticky LSB).
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t   r;
    int     ra, rb, ea, eb, d;
    longint ma, mb, big, sf;
    ra = int'(a[30:23]);
    rb = int'(b[30:23]);
    ea = (ra == 0) ? 1 : ra;
    eb = (rb == 0) ? 1 : rb;
    ma = longint'(a[22:0]) + ((ra != 0) ? (longint'(1) << 23) : 0);
    mb = longint'(b[22:0]) + ((rb != 0) ? (longint'(1) << 23) : 0);
    r.sw = (eb > ea);
    if (r.sw) begin
      r.e = 8'(eb); r.sb = b[31]; r.ss = a[31]; big = mb * 8; sf = ma * 8; d = eb - ea;
    end else begin
      r.e = 8'(ea); r.sb = a[31]; r.ss = b[31]; big = ma * 8; sf = mb * 8; d = ea - eb;
    end
    r.mb = 27'(big);
    r.sp = (ra == 255) || (rb == 255);
    if (r.sp) begin
      r.ms = 27'(sf);
      d    = 0;
    end else if (d > 26) begin
      r.ms = (sf != 0) ? 27'd1 : 27'd0;
      d    = 0;
    end else begin
      r.ms = 27'((sf >> d) | (((sf % (longint'(1) << d)) != 0) ? 1 : 0));
    end
`ifdef FPU_ALIGN_BARREL_EN
    r.lat = 1;
`else
    r.lat = 1 + (d + 3) / 4;
`endif
    return r;
  endfunction

  task automatic check_outputs(input string tag, input exp_t x);
    check({tag, ".exp"},        64'(out_exp),        64'(x.e));
    check({tag, ".sign_big"},   64'(out_sign_big),   64'(x.sb));
    check({tag, ".sign_small"}, 64'(out_sign_small), 64'(x.ss));
    check({tag, ".swap"},       64'(out_swap),       64'(x.sw));
    check({tag, ".special"},    64'(out_special),    64'(x.sp));
    check({tag, ".mant_big"},   64'(out_mant_big),   64'(x.mb));
    check({tag, ".mant_small"}, 64'(out_mant_small), 64'(x.ms));
  endtask

  // Present a pair from IDLE; returns at the negedge after the accept edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    in_a = a; in_b = b; in_valid = 1'b1;
    check("in_ready_idle", 64'(in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Called at the negedge after the accept edge; counts cycles to out_valid.
  task automatic wait_result(input string tag, input exp_t x);
    int lat;
    lat = 1;
    while (!out_valid && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    check({tag, ".latency"}, 64'(lat), 64'(x.lat));
    check_outputs(tag, x);
  endtask

  task automatic release_result(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, ".drained"}, 64'(out_valid), 64'd0);
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b);
    exp_t x;
    x = model(a, b);
    issue(a, b);
    wait_result(tag, x);
    release_result(tag);
    $display("op %s: a=%08h b=%08h exp=%02h big=%07h small=%07h lat=%0d",
             tag, a, b, x.e, x.mb, x.ms, x.lat);
  endtask

  initial begin
    exp_t x;
    int   seen;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0;

    // Reset values
    #12;
    check("rst.out_valid",  64'(out_valid),      64'd0);
    check("rst.in_ready",   64'(in_ready),       64'd1);
    check("rst.busy",       64'(busy),           64'd0);
    check("rst.exp",        64'(out_exp),        64'd0);
    check("rst.mant_big",   64'(out_mant_big),   64'd0);
    check("rst.mant_small", 64'(out_mant_small), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors
    run_op("one_two",  32'h3F800000, 32'h40000000);
    run_op("d24",      32'h3F800000, 32'h4B800000);
    run_op("collapse", 32'h3F800000, 32'h4D800000);
    run_op("special",  32'h7F800000, 32'h3F800000);
    run_op("tie",      32'hBFC00000, 32'h3F800001);
    run_op("denorm",   32'h00000005, 32'h00800000);

    // Stall in HOLD, then back-to-back accept during the handshake
    x = model(32'h3F800000, 32'h40000000);
    issue(32'h3F800000, 32'h40000000);
    wait_result("stall", x);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall.out_valid", 64'(out_valid), 64'd1);
      check("stall.in_ready",  64'(in_ready),  64'd0);
      check_outputs("stall", x);
    end
    x = model(32'h3F800000, 32'h4B800000);
    out_ready = 1'b1; in_a = 32'h3F800000; in_b = 32'h4B800000; in_valid = 1'b1;
    #1;
    check("b2b.in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    check("b2b.out_valid", 64'(out_valid), 64'(x.lat == 1));
    check("b2b.busy",      64'(busy),      64'd1);
    wait_result("b2b", x);
    release_result("b2b");
    $display("op stall/b2b: handshake with same-cycle accept done");

    // Asynchronous reset while aligning
    issue(32'h3F800000, 32'h4B800000);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst.out_valid",  64'(out_valid),      64'd0);
    check("arst.busy",       64'(busy),           64'd0);
    check("arst.in_ready",   64'(in_ready),       64'd1);
    check("arst.mant_small", 64'(out_mant_small), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    $display("op async_reset: applied mid-shift");

    // Flush while aligning
    issue(32'h3F800000, 32'h4B800000);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    check("flush.busy",      64'(busy),      64'd0);
    check("flush.out_valid", 64'(out_valid), 64'd0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("flush.no_valid", 64'(seen), 64'd0);
    $display("op flush: applied mid-shift");

    // Flush beats a simultaneous accept
    @(negedge clk);
    in_a = 32'h3F800000; in_b = 32'h40000000; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    check("flush_acc.busy", 64'(busy), 64'd0);
    $display("op flush_accept: accept dropped");

    // Randomized pairs
    for (int n = 0; n < 80; n++) begin
      int          ea, eb, mode;
      logic [31:0] a, b;
      mode = int'($urandom_range(0, 9));
      if (mode == 0)      ea = 0;
      else if (mode == 1) ea = 255;
      else                ea = int'($urandom_range(1, 254));
      eb = ea + int'($urandom_range(0, 70)) - 35;
      if (eb < 0)   eb = 0;
      if (eb > 255) eb = 255;
      a = {1'($urandom), 8'(ea), 23'($urandom)};
      b = {1'($urandom), 8'(eb), 23'($urandom)};
      if ($urandom_range(0, 1) == 1) run_op("rand", b, a);
      else                           run_op("rand", a, b);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
